// File: rtl/ef_i2s_tx.sv
// I2S master transmitter: sample FIFO feeding 32-bit-slot MSB-first serialiser; sdo moves on sck falling ticks.
// Writes are dropped when full, and the FIFO has no backpressure. Define EF_I2S_TX_UNDERFLOW_REPEAT_EN to re-send the last popped word per channel on underflow.
module ef_i2s_tx #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          sck,
    output logic          ws,
    output logic          sdo,
    input  logic          en,
    input  logic          left_justified,
    input  logic [1:0]    channels,
    input  logic [5:0]    sample_size,
    input  logic [7:0]    sck_prescaler,
    input  logic          fifo_wr,
    input  logic [31:0]   fifo_wdata,
    input  logic          fifo_clr,
    input  logic [AW:0]   fifo_level_threshold,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    input  logic          underflow_clr
);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [7:0]    r_presc;
    logic          r_sck;
    logic          r_ws;
    logic          r_sdo;
    logic          r_dly;
    logic          r_underflow;
    logic [4:0]    r_bit_ctr;
    logic [31:0]   r_sr;

    logic          w_tick;
    logic          w_fall;
    logic          w_edge;
    logic          w_next_ws;
    logic          w_pop_req;
    logic          w_pop;
    logic          w_push;
    logic          w_empty;
    logic          w_full;
    logic [5:0]    w_size;
    logic [5:0]    w_shamt;
    logic [31:0]   w_head;
    logic [31:0]   w_src;
    logic [31:0]   w_load;
    logic          w_bit;

    assign w_tick    = en & (r_presc == 8'd0);
    assign w_fall    = w_tick & r_sck;
    assign w_edge    = w_fall & (r_bit_ctr == 5'd0);
    assign w_next_ws = ~r_ws;
    // ws=0 is the left slot (channels[1]), ws=1 the right slot (channels[0])
    assign w_pop_req = w_edge & (w_next_ws ? channels[0] : channels[1]);
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_pop     = w_pop_req & ~w_empty;
    assign w_push    = fifo_wr & ~w_full;
    assign w_head    = r_mem[r_rptr];

    assign w_size  = ((sample_size == 6'd0) || (sample_size > 6'd32)) ? 6'd32 : sample_size;
    assign w_shamt = 6'd32 - w_size;

`ifdef EF_I2S_TX_UNDERFLOW_REPEAT_EN
    logic [31:0] r_hold_l;
    logic [31:0] r_hold_r;

    assign w_src = w_pop ? w_head : (w_pop_req ? (w_next_ws ? r_hold_r : r_hold_l) : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l <= 32'd0;
            r_hold_r <= 32'd0;
        end else if (w_pop) begin
            if (w_next_ws) r_hold_r <= w_head;
            else           r_hold_l <= w_head;
        end
    end
`else
    assign w_src = w_pop ? w_head : 32'd0;
`endif

    assign w_load = w_src << w_shamt;
    // Bit that a left-justified stream would show after this falling tick
    assign w_bit  = w_edge ? w_load[31] : r_sr[30];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= fifo_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (fifo_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= 8'd0;
            r_sck       <= 1'b0;
            r_ws        <= 1'b1;
            r_sdo       <= 1'b0;
            r_dly       <= 1'b0;
            r_bit_ctr   <= 5'd0;
            r_sr        <= 32'd0;
            r_underflow <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= sck_prescaler;
                r_sck   <= ~r_sck;
            end else if (en) begin
                r_presc <= r_presc - 8'd1;
            end
            if (w_fall) begin
                r_bit_ctr <= r_bit_ctr + 5'd1;
                r_sr      <= w_edge ? w_load : {r_sr[30:0], 1'b0};
                r_dly     <= w_bit;
                r_sdo     <= left_justified ? w_bit : r_dly;
                if (w_edge) r_ws <= w_next_ws;
            end
            if (w_pop_req && w_empty) r_underflow <= 1'b1;
            else if (underflow_clr)   r_underflow <= 1'b0;
        end
    end

    assign sck              = r_sck;
    assign ws               = r_ws;
    assign sdo              = r_sdo;
    assign fifo_full        = w_full;
    assign fifo_empty       = w_empty;
    assign fifo_level       = r_level;
    assign fifo_level_below = (r_level < fifo_level_threshold);
    assign underflow        = r_underflow;
endmodule
